// File: rtl/morse_keyer.sv
// +----------------------------------------------------------------------------+
// | morse_keyer                                                                |
// | Stretches decoder symbols (dot/dash/gap) into Morse-timed key and sidetone |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module morse_keyer #(
  parameter int UNIT_CYCLES      = 4,
  parameter int TONE_HALF_PERIOD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       abort,
  input  logic [2:0] sym_in,
  output logic       req,
  output logic       key_out,
  output logic       tone_out,
  output logic       busy
);

  localparam int c_cyc_w  = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int c_tone_w = (TONE_HALF_PERIOD > 1) ? $clog2(TONE_HALF_PERIOD) : 1;

  localparam logic [c_cyc_w-1:0]  c_cyc_last  = c_cyc_w'(UNIT_CYCLES - 1);
  localparam logic [c_tone_w-1:0] c_tone_last = c_tone_w'(TONE_HALF_PERIOD - 1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_mark  = 2'd1;
  localparam logic [1:0] c_st_space = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [1:0]          unit_q, unit_d;
  logic [c_cyc_w-1:0]  cyc_q, cyc_d;
  logic                key_q, key_d;
  logic [c_tone_w-1:0] tone_cnt_q, tone_cnt_d;
  logic                phase_q, phase_d;

  logic cyc_wrap;
  logic elem_last;
  logic sym_unused;

  assign cyc_wrap   = (cyc_q == c_cyc_last);
  assign elem_last  = cyc_wrap && (unit_q == 2'd1);
  // Bit 0 carries no meaning for this consumer.
  assign sym_unused = sym_in[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= c_st_idle;
      unit_q     <= 2'd0;
      cyc_q      <= '0;
      key_q      <= 1'b0;
      tone_cnt_q <= '0;
      phase_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      unit_q     <= unit_d;
      cyc_q      <= cyc_d;
      key_q      <= key_d;
      tone_cnt_q <= tone_cnt_d;
      phase_q    <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    cyc_d   = cyc_q;
    if (abort) begin
      state_d = c_st_idle;
      unit_d  = 2'd0;
      cyc_d   = '0;
    end else begin
      case (state_q)
        c_st_idle: begin
          if (req) begin
            cyc_d = '0;
            if (sym_in[1]) begin
              state_d = c_st_mark;
              unit_d  = sym_in[2] ? 2'd3 : 2'd1;
            end else begin
              state_d = c_st_space;
              unit_d  = 2'd2;
            end
          end
        end
        c_st_mark: begin
          if (cyc_wrap) begin
            cyc_d = '0;
            if (unit_q == 2'd1) begin
              state_d = c_st_space;
              unit_d  = 2'd1;
            end else begin
              unit_d = unit_q - 2'd1;
            end
          end else begin
            cyc_d = cyc_q + c_cyc_w'(1);
          end
        end
        c_st_space: begin
          if (cyc_wrap) begin
            cyc_d = '0;
            if (unit_q == 2'd1) begin
              // Chain straight into the next element when the decoder is pulled.
              if (req) begin
                if (sym_in[1]) begin
                  state_d = c_st_mark;
                  unit_d  = sym_in[2] ? 2'd3 : 2'd1;
                end else begin
                  state_d = c_st_space;
                  unit_d  = 2'd2;
                end
              end else begin
                state_d = c_st_idle;
                unit_d  = 2'd0;
              end
            end else begin
              unit_d = unit_q - 2'd1;
            end
          end else begin
            cyc_d = cyc_q + c_cyc_w'(1);
          end
        end
        default: begin
          state_d = c_st_idle;
          unit_d  = 2'd0;
          cyc_d   = '0;
        end
      endcase
    end

    key_d = (state_d == c_st_mark);

    // Sidetone phase only runs while the key is down, so each mark starts at phase 0.
    tone_cnt_d = tone_cnt_q;
    phase_d    = phase_q;
    if (!key_q || abort) begin
      tone_cnt_d = '0;
      phase_d    = 1'b0;
    end else if (tone_cnt_q == c_tone_last) begin
      tone_cnt_d = '0;
      phase_d    = ~phase_q;
    end else begin
      tone_cnt_d = tone_cnt_q + c_tone_w'(1);
    end
  end

  always_comb begin
    req      = rst_n & en & ~abort &
               ((state_q == c_st_idle) | ((state_q == c_st_space) & elem_last));
    busy     = (state_q != c_st_idle);
    key_out  = key_q;
    tone_out = key_q & phase_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_morse_keyer.sv
// +----------------------------------------------------------------------------+
// | tb_morse_keyer                                                             |
// | Scoreboard bench for morse_keyer, two parameterisations in lock-step       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_morse_keyer;

  localparam int U0 = 4;
  localparam int T0 = 2;
  localparam int U1 = 1;
  localparam int T1 = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] sym_in = 3'b000;

  logic req0, key0, tone0, busy0;
  logic req1, key1, tone1, busy1;

  always #5 clk = ~clk;

  morse_keyer #(.UNIT_CYCLES(U0), .TONE_HALF_PERIOD(T0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .abort(abort), .sym_in(sym_in),
    .req(req0), .key_out(key0), .tone_out(tone0), .busy(busy0)
  );

  morse_keyer #(.UNIT_CYCLES(U1), .TONE_HALF_PERIOD(T1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .abort(abort), .sym_in(sym_in),
    .req(req1), .key_out(key1), .tone_out(tone1), .busy(busy1)
  );

  typedef struct packed {
    logic [3:0] e0;
    logic [3:0] e1;
  } exp_t;

  typedef struct {
    int         n;
    logic       en;
    logic       abort;
    logic [2:0] sym;
    logic       rst_n;
  } stim_t;

  exp_t exp_q[$];
  // Per instance: one entry per future cycle of the active element;
  // mark cycles hold their index within the mark, space cycles hold -1.
  int   tl[2][$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  stim_t dir[12] = '{
    '{3,  1'b0, 1'b0, 3'b000, 1'b0},
    '{24, 1'b1, 1'b0, 3'b010, 1'b1},
    '{48, 1'b1, 1'b0, 3'b110, 1'b1},
    '{8,  1'b1, 1'b0, 3'b010, 1'b1},
    '{8,  1'b1, 1'b0, 3'b000, 1'b1},
    '{18, 1'b1, 1'b0, 3'b110, 1'b1},
    '{20, 1'b0, 1'b0, 3'b110, 1'b1},
    '{6,  1'b1, 1'b0, 3'b110, 1'b1},
    '{1,  1'b1, 1'b1, 3'b110, 1'b1},
    '{3,  1'b1, 1'b0, 3'b010, 1'b1},
    '{2,  1'b1, 1'b0, 3'b010, 1'b0},
    '{16, 1'b1, 1'b0, 3'b100, 1'b1}
  };

  task automatic model_step(input int i, input int u, input int thp, output logic [3:0] o);
    int   k;
    int   n;
    logic r;
    if (!rst_n) begin
      tl[i].delete();
      o = 4'b0000;
    end else begin
      k = (tl[i].size() > 0) ? tl[i][0] : -1;
      r = en && !abort && (tl[i].size() <= 1);
      o = {r, (k >= 0), (k >= 0) && (((k / thp) % 2) == 1), (tl[i].size() > 0)};
      if (abort) begin
        tl[i].delete();
      end else begin
        if (tl[i].size() > 0) void'(tl[i].pop_front());
        if (r) begin
          if (sym_in[1]) begin
            n = sym_in[2] ? 3 : 1;
            for (int j = 0; j < n * u; j++) tl[i].push_back(j);
            for (int j = 0; j < u; j++) tl[i].push_back(-1);
          end else begin
            for (int j = 0; j < 2 * u; j++) tl[i].push_back(-1);
          end
        end
      end
    end
  endtask

  task automatic drive(input logic e, input logic a, input logic [2:0] s, input logic rs);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n  = rs;
    en     = e;
    abort  = a;
    sym_in = s;
    model_step(0, U0, T0, x.e0);
    model_step(1, U1, T1, x.e1);
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin : mon
    exp_t       x;
    logic [3:0] a0;
    logic [3:0] a1;
    if (exp_q.size() > 0) begin
      x  = exp_q.pop_front();
      a0 = {req0, key0, tone0, busy0};
      a1 = {req1, key1, tone1, busy1};
      vectors = vectors + 2;
      if (a0 !== x.e0) begin
        miscompares = miscompares + 1;
        $display("FAIL dut_u4 cyc %0d: req/key/tone/busy got %b expected %b", cyc, a0, x.e0);
      end
      if (a1 !== x.e1) begin
        miscompares = miscompares + 1;
        $display("FAIL dut_u1 cyc %0d: req/key/tone/busy got %b expected %b", cyc, a1, x.e1);
      end
      cyc = cyc + 1;
    end
  end

  initial begin
    logic       e;
    logic       a;
    logic       rs;
    logic [2:0] s;
    int         r;

    for (int t = 0; t < 12; t++) begin
      for (int c = 0; c < dir[t].n; c++) begin
        drive(dir[t].en, dir[t].abort, dir[t].sym, dir[t].rst_n);
      end
    end

    for (int c = 0; c < 3000; c++) begin
      rs = ($urandom_range(0, 299) != 0);
      a  = ($urandom_range(0, 39) == 0);
      e  = ($urandom_range(0, 9) != 0);
      r  = $urandom_range(0, 9);
      if (r < 4)      s = 3'b010;
      else if (r < 7) s = 3'b110;
      else if (r < 9) s = 3'b000;
      else            s = 3'($urandom_range(0, 7));
      drive(e, a, s, rs);
    end

    @(negedge clk);
    @(negedge clk);
    vectors = vectors + 1;
    if (exp_q.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
